// File: rtl/ad_capture_pack.sv
`default_nettype none
// ============================================================================
// ad_capture_pack : triggered ADC capture window packing PACK samples per word.
// Optional peak tracker (o_peak / o_peak_idx) under `define AD_CAPTURE_PEAK_EN.
// Revision: 1.0
// ============================================================================
module ad_capture_pack #(
  parameter int DSIZE = 8,
  parameter int PACK  = 2,
  parameter int CNT_W = 16
) (
  input  logic                  i_ad_clk,
  input  logic                  i_rst_n,
  input  logic                  i_st,
  input  logic                  i_abort,
  input  logic [DSIZE-1:0]      i_ad_data,
  input  logic [CNT_W-1:0]      i_recv_count,
  input  logic [7:0]            i_delay,
  input  logic [3:0]            i_decim,
  output logic [DSIZE*PACK-1:0] o_pack_data,
  output logic                  o_valid,
  output logic                  o_last,
  output logic                  o_working,
`ifdef AD_CAPTURE_PEAK_EN
  output logic                  o_done,
  output logic [DSIZE-1:0]      o_peak,
  output logic [CNT_W-1:0]      o_peak_idx
`else
  output logic                  o_done
`endif
);

  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [LANE_W-1:0] C_LANE_LAST = LANE_W'(PACK - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DELAY   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_st_q;
  logic [CNT_W-1:0]        r_count;
  logic [3:0]              r_decim;
  logic [7:0]              r_dly_cnt;
  logic [3:0]              r_dec_cnt;
  logic [CNT_W-1:0]        r_smp_idx;
  logic [LANE_W-1:0]       r_lane;
  logic [DSIZE*PACK-1:0]   r_acc;
  logic [DSIZE*PACK-1:0]   w_word;
  logic                    w_edge;
  logic                    w_accept;
  logic                    w_last_smp;
  logic                    w_flush;

  assign w_edge     = i_st & ~r_st_q;
  assign w_accept   = (r_state == S_CAPTURE) && (r_dec_cnt == 4'd0);
  assign w_last_smp = w_accept && (r_smp_idx == (r_count - CNT_W'(1)));
  assign w_flush    = w_accept && ((r_lane == C_LANE_LAST) || w_last_smp);
  assign o_working  = (r_state == S_DELAY) || (r_state == S_CAPTURE);
  assign o_done     = (r_state == S_DONE);

  // Accumulator with the current sample dropped into its lane.
  always_comb begin
    w_word = r_acc;
    for (int k = 0; k < PACK; k++) begin
      if (r_lane == LANE_W'(k)) begin
        w_word[k*DSIZE +: DSIZE] = i_ad_data;
      end
    end
  end

  always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_edge) begin
          if (i_recv_count == '0) begin
            w_state_nxt = S_DONE;
          end else if (i_delay == 8'd0) begin
            w_state_nxt = S_CAPTURE;
          end else begin
            w_state_nxt = S_DELAY;
          end
        end
      end
      S_DELAY: begin
        if (r_dly_cnt == 8'd1) begin
          w_state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (w_last_smp) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort overrides everything, including a final-sample completion.
    if (i_abort) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st_q      <= 1'b0;
      r_count     <= '0;
      r_decim     <= '0;
      r_dly_cnt   <= '0;
      r_dec_cnt   <= '0;
      r_smp_idx   <= '0;
      r_lane      <= '0;
      r_acc       <= '0;
      o_pack_data <= '0;
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
    end else begin
      r_st_q  <= i_st;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      if (i_abort) begin
        r_acc  <= '0;
        r_lane <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_edge) begin
              r_count   <= i_recv_count;
              r_decim   <= i_decim;
              r_dly_cnt <= i_delay;
              r_dec_cnt <= 4'd0;
              r_smp_idx <= '0;
              r_acc     <= '0;
              r_lane    <= '0;
            end
          end
          S_DELAY: begin
            r_dly_cnt <= r_dly_cnt - 8'd1;
          end
          S_CAPTURE: begin
            if (w_accept) begin
              r_dec_cnt <= r_decim;
              r_smp_idx <= r_smp_idx + CNT_W'(1);
              if (w_flush) begin
                o_pack_data <= w_word;
                o_valid     <= 1'b1;
                o_last      <= w_last_smp;
                r_acc       <= '0;
                r_lane      <= '0;
              end else begin
                r_acc  <= w_word;
                r_lane <= r_lane + LANE_W'(1);
              end
            end else begin
              r_dec_cnt <= r_dec_cnt - 4'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef AD_CAPTURE_PEAK_EN
  // Strict compare keeps the index of the first occurrence of the maximum.
  always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_peak     <= '0;
      o_peak_idx <= '0;
    end else if (i_abort) begin
      o_peak     <= '0;
      o_peak_idx <= '0;
    end else if ((r_state == S_IDLE) && w_edge) begin
      o_peak     <= '0;
      o_peak_idx <= '0;
    end else if (w_accept && (i_ad_data > o_peak)) begin
      o_peak     <= i_ad_data;
      o_peak_idx <= r_smp_idx;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ad_capture_pack.sv
`default_nettype none
// ============================================================================
// tb_ad_capture_pack : directed stimulus, per-cycle window model, literal checks.
// Revision: 1.0
// ============================================================================
module tb_ad_capture_pack;

  localparam int DSIZE = 8;
  localparam int PACK  = 2;
  localparam int CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  st = 1'b0;
  logic                  abort_i = 1'b0;
  logic [DSIZE-1:0]      ad_data = '0;
  logic [CNT_W-1:0]      recv_count = '0;
  logic [7:0]            delay = '0;
  logic [3:0]            decim = '0;
  logic [DSIZE*PACK-1:0] pack_data;
  logic                  valid, last, working, done;
`ifdef AD_CAPTURE_PEAK_EN
  logic [DSIZE-1:0]      peak;
  logic [CNT_W-1:0]      peak_idx;
`endif

  always #5 clk = ~clk;

  ad_capture_pack #(.DSIZE(DSIZE), .PACK(PACK), .CNT_W(CNT_W)) dut (
    .i_ad_clk     (clk),
    .i_rst_n      (rst_n),
    .i_st         (st),
    .i_abort      (abort_i),
    .i_ad_data    (ad_data),
    .i_recv_count (recv_count),
    .i_delay      (delay),
    .i_decim      (decim),
    .o_pack_data  (pack_data),
    .o_valid      (valid),
    .o_last       (last),
    .o_working    (working),
`ifdef AD_CAPTURE_PEAK_EN
    .o_done       (done),
    .o_peak       (peak),
    .o_peak_idx   (peak_idx)
`else
    .o_done       (done)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  // Window model: accept edges are n0+1+delay+k*(decim+1), k < count.
  int               m_n = 0;
  int               m_n0 = 0;
  int               m_d = 0;
  int               m_m = 0;
  int               m_cnt = 0;
  int               m_done_edge = -10;
  logic             m_active = 1'b0;
  logic             m_st_prev = 1'b0;
  logic [DSIZE-1:0] m_buf[$];
  logic [DSIZE*PACK-1:0] e_data = '0;
  logic             e_valid = 1'b0, e_last = 1'b0, e_done = 1'b0, e_work = 1'b0;
  logic [DSIZE-1:0] e_peak = '0;
  int               e_idx = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_active = 1'b0; m_st_prev = 1'b0; m_done_edge = -10;
      m_buf.delete();
      e_data = '0; e_valid = 1'b0; e_last = 1'b0; e_done = 1'b0; e_work = 1'b0;
      e_peak = '0; e_idx = 0;
    end else begin
      m_n++;
      e_valid = 1'b0; e_last = 1'b0; e_done = 1'b0; e_work = 1'b0;
      if (abort_i) begin
        m_active = 1'b0;
        m_buf.delete();
        e_peak = '0; e_idx = 0;
      end else if (m_active) begin
        int rel;
        rel = m_n - m_n0 - 1 - m_d;
        e_work = 1'b1;
        if (rel >= 0 && (rel % (m_m + 1)) == 0) begin
          int k;
          k = rel / (m_m + 1);
          m_buf.push_back(ad_data);
          if (ad_data > e_peak) begin
            e_peak = ad_data; e_idx = k;
          end
          if (m_buf.size() == PACK || k == m_cnt - 1) begin
            e_data = '0;
            for (int j = 0; j < m_buf.size(); j++) e_data[j*DSIZE +: DSIZE] = m_buf[j];
            e_valid = 1'b1;
            e_last  = (k == m_cnt - 1);
            m_buf.delete();
          end
          if (k == m_cnt - 1) begin
            e_done = 1'b1; e_work = 1'b0; m_active = 1'b0; m_done_edge = m_n;
          end
        end
      end else if (m_n != m_done_edge + 1 && st && !m_st_prev) begin
        m_n0 = m_n; m_d = int'(delay); m_m = int'(decim); m_cnt = int'(recv_count);
        m_buf.delete();
        e_peak = '0; e_idx = 0;
        if (m_cnt == 0) begin
          e_done = 1'b1; m_done_edge = m_n;
        end else begin
          m_active = 1'b1; e_work = 1'b1;
        end
      end
      m_st_prev = st;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic ok;
      ok = (valid === e_valid) && (last === e_last) && (done === e_done) &&
           (working === e_work) && (pack_data === e_data);
`ifdef AD_CAPTURE_PEAK_EN
      ok = ok && (peak === e_peak) && (int'(peak_idx) == e_idx);
`endif
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL model cycle %0d: got v=%b l=%b d=%b w=%b data=%h, expected v=%b l=%b d=%b w=%b data=%h",
                    m_n, valid, last, done, working, pack_data, e_valid, e_last, e_done, e_work, e_data);
    end
  end

  // Directed-test log, gathered in the stimulus process itself.
  logic [DSIZE*PACK-1:0] words[$];
  logic                  lasts[$];
  int                    n_done = 0;
  int                    n_work = 0;
  logic [7:0]            ramp = '0;

  task automatic tick_d(input logic [7:0] d);
    @(negedge clk);
    if (valid) begin
      words.push_back(pack_data); lasts.push_back(last);
    end
    if (done) n_done++;
    if (working) n_work++;
    ad_data = d;
  endtask

  task automatic tick();
    tick_d(ramp);
    ramp = ramp + 8'd1;
  endtask

  task automatic clear_log();
    words.delete(); lasts.delete(); n_done = 0; n_work = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Trigger, then scramble the parameters to prove they were latched.
  task automatic trigger(input int cnt, input int dly, input int dec);
    recv_count = CNT_W'(cnt); delay = 8'(dly); decim = 4'(dec); st = 1'b1;
    tick();
    st = 1'b0; recv_count = 16'd99; delay = 8'd77; decim = 4'd5;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    clear_log();
    repeat (100) tick();
    check("idle_words", words.size(), 0);
    check("idle_done", n_done, 0);
    check("idle_work", n_work, 0);

    // delay=3 decim=0 count=6
    clear_log(); ramp = 8'h0C; tick();
    trigger(6, 3, 0);
    repeat (15) tick();
    check("t2_work", n_work, 9);
    check("t2_nwords", words.size(), 3);
    if (words.size() == 3) begin
      check("t2_w0", words[0], 32'h1110);
      check("t2_w1", words[1], 32'h1312);
      check("t2_w2", words[2], 32'h1514);
      check("t2_last0", lasts[0], 0);
      check("t2_last2", lasts[2], 1);
    end
    check("t2_done", n_done, 1);

    // decim=2 count=5, partial final word
    clear_log(); ramp = 8'h1F; tick();
    trigger(5, 0, 2);
    repeat (20) tick();
    check("t3_nwords", words.size(), 3);
    if (words.size() == 3) begin
      check("t3_w0", words[0], 32'h2320);
      check("t3_w1", words[1], 32'h2926);
      check("t3_w2", words[2], 32'h002C);
      check("t3_last2", lasts[2], 1);
    end
    check("t3_work", n_work, 13);

    // Abort after three samples, then retrigger
    clear_log(); ramp = 8'h3F; tick();
    trigger(8, 0, 0);
    repeat (3) tick();
    abort_i = 1'b1; tick(); abort_i = 1'b0;
    tick();
    check("t4_idle_after_abort", working, 0);
    repeat (10) tick();
    check("t4_nwords", words.size(), 1);
    if (words.size() == 1) check("t4_w0", words[0], 32'h4140);
    check("t4_nodone", n_done, 0);
    clear_log(); ramp = 8'h50; tick();
    trigger(2, 1, 0);
    repeat (8) tick();
    check("t4_retrig_nwords", words.size(), 1);
    if (words.size() == 1) check("t4_retrig_w0", words[0], 32'h5352);
    check("t4_retrig_done", n_done, 1);

    // Mid-window re-trigger ignored; count=0 window
    clear_log(); ramp = 8'h60; tick();
    trigger(4, 2, 1);
    repeat (3) tick();
    st = 1'b1; tick(); st = 1'b0;
    repeat (12) tick();
    check("t5_nwords", words.size(), 2);
    if (words.size() == 2) begin
      check("t5_w0", words[0], 32'h6563);
      check("t5_w1", words[1], 32'h6967);
    end
    check("t5_done", n_done, 1);
    clear_log(); tick();
    trigger(0, 5, 0);
    repeat (5) tick();
    check("t5_zero_done", n_done, 1);
    check("t5_zero_nwords", words.size(), 0);
    check("t5_zero_work", n_work, 0);

    // Abort on the final sample edge
    clear_log(); ramp = 8'h70; tick();
    trigger(2, 0, 0);
    tick();
    abort_i = 1'b1; tick(); abort_i = 1'b0;
    repeat (5) tick();
    check("abort_last_nwords", words.size(), 0);
    check("abort_last_nodone", n_done, 0);

    // Data 5,9,3,9
    clear_log(); tick_d(8'h00);
    ramp = 8'h05;
    trigger(4, 0, 0);
    tick_d(8'h09); tick_d(8'h03); tick_d(8'h09);
    repeat (6) tick();
    check("t6_nwords", words.size(), 2);
    if (words.size() == 2) begin
      check("t6_w0", words[0], 32'h0905);
      check("t6_w1", words[1], 32'h0903);
    end
    check("t6_done", n_done, 1);
`ifdef AD_CAPTURE_PEAK_EN
    check("t6_peak", peak, 32'h9);
    check("t6_peak_idx", peak_idx, 32'h1);
`endif

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
